// File: rtl/accumulator_alu.sv
// Accumulator-side ALU stage: single-cycle logic/arithmetic ops plus a
// multi-cycle unsigned shift-add multiply with a busy/done handshake.
module accumulator_alu #(
  parameter int unsigned DATA_WIDTH = 11
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] operand_b_in,
  input  logic [2:0]            op_sel,
  input  logic                  op_valid,
  output logic                  busy,
  output logic                  op_done,
  output logic [DATA_WIDTH-1:0] acc_out,
  output logic                  zero_flag,
  output logic                  negative_flag,
  output logic                  carry_flag,
  output logic                  overflow_flag
);

  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, MUL} state_t;
  typedef enum logic [2:0] {
    OP_LDA = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_AND = 3'd3,
    OP_OR  = 3'd4, OP_XOR = 3'd5, OP_NOT = 3'd6, OP_MUL = 3'd7
  } op_t;

  state_t                    state_q, state_d;
  logic [DATA_WIDTH-1:0]     acc_q, acc_d;
  logic                      z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
  logic                      done_q, done_d;
  logic [2*DATA_WIDTH-1:0]   mcand_q, mcand_d, prod_q, prod_d;
  logic [DATA_WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]             cnt_q, cnt_d;

  logic [DATA_WIDTH:0]       add_sum, sub_sum;
  logic [2*DATA_WIDTH-1:0]   prod_step;
  logic [DATA_WIDTH-1:0]     res;
  logic                      res_c, res_v, write_res;
  op_t                       op;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      z_q      <= z_d;
      n_q      <= n_d;
      c_q      <= c_d;
      v_q      <= v_d;
      done_q   <= done_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    z_d       = z_q;
    n_d       = n_q;
    c_d       = c_q;
    v_d       = v_q;
    done_d    = 1'b0;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    res       = '0;
    res_c     = 1'b0;
    res_v     = 1'b0;
    write_res = 1'b0;
    op        = op_t'(op_sel);

    add_sum   = {1'b0, acc_q} + {1'b0, operand_b_in};
    sub_sum   = {1'b0, acc_q} + {1'b0, ~operand_b_in} + (DATA_WIDTH+1)'(1);
    prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      IDLE: begin
        if (op_valid) begin
          if (op == OP_MUL) begin
            mcand_d  = {{DATA_WIDTH{1'b0}}, acc_q};
            mplier_d = operand_b_in;
            prod_d   = '0;
            cnt_d    = '0;
            state_d  = MUL;
          end else begin
            write_res = 1'b1;
            case (op)
              OP_LDA: res = operand_b_in;
              OP_ADD: begin
                res   = add_sum[DATA_WIDTH-1:0];
                res_c = add_sum[DATA_WIDTH];
                res_v = (acc_q[DATA_WIDTH-1] == operand_b_in[DATA_WIDTH-1]) &&
                        (res[DATA_WIDTH-1] != acc_q[DATA_WIDTH-1]);
              end
              OP_SUB: begin
                res   = sub_sum[DATA_WIDTH-1:0];
                res_c = sub_sum[DATA_WIDTH];
                res_v = (acc_q[DATA_WIDTH-1] != operand_b_in[DATA_WIDTH-1]) &&
                        (res[DATA_WIDTH-1] != acc_q[DATA_WIDTH-1]);
              end
              OP_AND:  res = acc_q & operand_b_in;
              OP_OR:   res = acc_q | operand_b_in;
              OP_XOR:  res = acc_q ^ operand_b_in;
              default: res = ~acc_q;
            endcase
          end
        end
      end
      MUL: begin
        // One multiplier bit per edge; the final edge commits the step it also computes.
        prod_d   = prod_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          write_res = 1'b1;
          res       = prod_step[DATA_WIDTH-1:0];
          res_c     = |prod_step[2*DATA_WIDTH-1:DATA_WIDTH];
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (write_res) begin
      acc_d  = res;
      z_d    = (res == '0);
      n_d    = res[DATA_WIDTH-1];
      c_d    = res_c;
      v_d    = res_v;
      done_d = 1'b1;
    end
  end

  assign busy          = (state_q == MUL);
  assign op_done       = done_q;
  assign acc_out       = acc_q;
  assign zero_flag     = z_q;
  assign negative_flag = n_q;
  assign carry_flag    = c_q;
  assign overflow_flag = v_q;

endmodule

// File: tb/tb_accumulator_alu.sv
// Directed self-checking bench for accumulator_alu (DATA_WIDTH = 11).
module tb_accumulator_alu;

  localparam int unsigned W = 11;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [W-1:0] operand_b_in;
  logic [2:0]   op_sel;
  logic         op_valid;
  logic         busy, op_done;
  logic [W-1:0] acc_out;
  logic         zero_flag, negative_flag, carry_flag, overflow_flag;

  int checks = 0;
  int errors = 0;
  int cycles, dones;

  accumulator_alu #(.DATA_WIDTH(W)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .operand_b_in  (operand_b_in),
    .op_sel        (op_sel),
    .op_valid      (op_valid),
    .busy          (busy),
    .op_done       (op_done),
    .acc_out       (acc_out),
    .zero_flag     (zero_flag),
    .negative_flag (negative_flag),
    .carry_flag    (carry_flag),
    .overflow_flag (overflow_flag)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request for a single edge, then return #1 after that edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] b);
    op_sel       = op;
    operand_b_in = b;
    op_valid     = 1'b1;
    @(posedge clock); #1;
    op_valid     = 1'b0;
  endtask

  function automatic logic [31:0] flags();
    return {28'd0, zero_flag, negative_flag, carry_flag, overflow_flag};
  endfunction

  // Follow a multiply just after its accept edge until busy drops (bounded).
  // Optionally pulses an LDA 0 request during busy cycle inject_at.
  task automatic wait_mul(input int inject_at, output int n, output int d);
    int guard;
    n = busy ? 1 : 0;
    d = 0;
    guard = 0;
    while (busy && guard < 40) begin
      if (n == inject_at) begin
        op_sel = 3'd0; operand_b_in = '0; op_valid = 1'b1;
      end else begin
        op_valid = 1'b0;
      end
      @(posedge clock); #1;
      guard++;
      if (op_done && busy) check("done_while_busy", 32'(op_done), 32'd0);
      if (busy) n++;
      if (op_done) d++;
    end
    op_valid = 1'b0;
    if (guard >= 40) check("mul_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; op_valid = 1'b1; op_sel = 3'd1; operand_b_in = 11'h7FF;
    repeat (2) @(posedge clock);
    #1;
    check("rst_acc", 32'(acc_out), 32'd0);
    check("rst_flags", flags(), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(op_done), 32'd0);
    reset_n = 1'b1; op_valid = 1'b0;
    @(posedge clock); #1;
    check("idle_acc", 32'(acc_out), 32'd0);

    issue(3'd0, 11'b00001001001);
    check("lda_acc", 32'(acc_out), 32'd73);
    check("lda_done", 32'(op_done), 32'd1);
    @(posedge clock); #1;
    check("lda_done_pulse", 32'(op_done), 32'd0);

    issue(3'd1, 11'b11101001001);
    check("add_acc", 32'(acc_out), 32'h792);
    check("add_flags", flags(), 32'b0100);

    issue(3'd0, 11'd1023);
    issue(3'd1, 11'd1);
    check("addv_acc", 32'(acc_out), 32'h400);
    check("addv_flags", flags(), 32'b0101);
    issue(3'd1, 11'h400);
    check("addwrap_acc", 32'(acc_out), 32'd0);
    check("addwrap_flags", flags(), 32'b1011);

    issue(3'd0, 11'b00001100100);
    issue(3'd2, 11'd100);
    check("sub0_acc", 32'(acc_out), 32'd0);
    check("sub0_flags", flags(), 32'b1010);
    issue(3'd2, 11'd1);
    check("subb_acc", 32'(acc_out), 32'h7FF);
    check("subb_flags", flags(), 32'b0100);

    issue(3'd3, 11'h0F0);
    check("and_acc", 32'(acc_out), 32'h0F0);
    check("and_flags", flags(), 32'b0000);
    issue(3'd4, 11'h40F);
    check("or_acc", 32'(acc_out), 32'h4FF);
    issue(3'd5, 11'h0FF);
    check("xor_acc", 32'(acc_out), 32'h400);
    issue(3'd6, 11'h123);
    check("not_acc", 32'(acc_out), 32'h3FF);
    check("not_flags", flags(), 32'b0000);

    issue(3'd0, 11'd100);
    issue(3'd7, 11'd20);
    check("mul_busy", 32'(busy), 32'd1);
    check("mul_accept_done", 32'(op_done), 32'd0);
    check("mul_acc_hold", 32'(acc_out), 32'd100);
    wait_mul(3, cycles, dones);
    check("mul_busy_cycles", 32'(cycles), 32'd11);
    check("mul_done_count", 32'(dones), 32'd1);
    check("mul_acc", 32'(acc_out), 32'h7D0);
    check("mul_flags", flags(), 32'b0100);
    @(posedge clock); #1;
    check("mul_inject_ignored", 32'(acc_out), 32'h7D0);
    check("mul_done_pulse", 32'(op_done), 32'd0);

    issue(3'd7, 11'd3);
    wait_mul(-1, cycles, dones);
    check("mul3_busy_cycles", 32'(cycles), 32'd11);
    check("mul3_acc", 32'(acc_out), 32'd1904);
    check("mul3_flags", flags(), 32'b0110);

    issue(3'd0, 11'd7);
    issue(3'd7, 11'd9);
    repeat (4) @(posedge clock);
    #1;
    check("abort_busy_pre", 32'(busy), 32'd1);
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    check("abort_acc", 32'(acc_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(op_done), 32'd0);
    dones = 0;
    repeat (12) begin
      @(posedge clock); #1;
      if (op_done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    issue(3'd0, 11'd5);
    check("post_abort_acc", 32'(acc_out), 32'd5);
    check("post_abort_done", 32'(op_done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
